// File: rtl/disp_pkg.sv
// Shared constants for the reaction-timer seven-segment display path:
// digit codes, active-low segment glyphs and the scan FSM state type.
package disp_pkg;

    // Input digit codes with a special meaning
    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_H     = 4'h5;
    localparam logic [3:0] CODE_I     = 4'hA;

    // Full segment word with every segment and the dp dark
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    // Active-low glyphs for segments g..a (dp carried separately)
    localparam logic [6:0] GLYPH_0    = 7'h40;
    localparam logic [6:0] GLYPH_1    = 7'h79;
    localparam logic [6:0] GLYPH_2    = 7'h24;
    localparam logic [6:0] GLYPH_3    = 7'h30;
    localparam logic [6:0] GLYPH_4    = 7'h19;
    localparam logic [6:0] GLYPH_5    = 7'h12;
    localparam logic [6:0] GLYPH_6    = 7'h02;
    localparam logic [6:0] GLYPH_7    = 7'h78;
    localparam logic [6:0] GLYPH_8    = 7'h00;
    localparam logic [6:0] GLYPH_9    = 7'h10;
    localparam logic [6:0] GLYPH_H    = 7'h09;
    localparam logic [6:0] GLYPH_I    = 7'h4F;
    localparam logic [6:0] GLYPH_OFF  = 7'h7F;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } disp_state_t;

    // Decimal glyph lookup; codes above 9 map to all segments off
    function automatic logic [6:0] num_glyph(input logic [3:0] code);
        case (code)
            4'd0:    num_glyph = GLYPH_0;
            4'd1:    num_glyph = GLYPH_1;
            4'd2:    num_glyph = GLYPH_2;
            4'd3:    num_glyph = GLYPH_3;
            4'd4:    num_glyph = GLYPH_4;
            4'd5:    num_glyph = GLYPH_5;
            4'd6:    num_glyph = GLYPH_6;
            4'd7:    num_glyph = GLYPH_7;
            4'd8:    num_glyph = GLYPH_8;
            4'd9:    num_glyph = GLYPH_9;
            default: num_glyph = GLYPH_OFF;
        endcase
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational digit-code to active-low segment decoder.
// Number mode shows 0..9 (other codes blank) with an optional dp;
// letter mode shows 'H' and 'I' only and never lights the dp.
module seg_decoder
    import disp_pkg::*;
(
    input  logic [3:0] code,
    input  logic       ltr,
    input  logic       dp_en,
    input  logic       blank_force,
    output logic [7:0] sseg
);

    // Pick the glyph; anything not explicitly recognised stays dark
    always_comb begin
        // NOTE: default first so every path assigns sseg and no latch is inferred.
        sseg = SEG_BLANK;
        if (!blank_force) begin
            if (ltr) begin
                case (code)
                    CODE_H:  sseg = {1'b1, GLYPH_H};
                    CODE_I:  sseg = {1'b1, GLYPH_I};
                    default: sseg = SEG_BLANK;
                endcase
            end else if (code <= 4'd9) begin
                // dp is active-low and only ever rides on a visible digit
                sseg = {~dp_en, num_glyph(code)};
            end
        end
    end

endmodule

// File: rtl/reaction_display_mux.sv
// Time-multiplexed 4-digit seven-segment driver for the reaction timer.
// Snapshots the digit codes once per frame (no tearing) and blanks the
// first GAP_CYC cycles of each digit slot (no ghosting).
// Optional build macro: LEAD_ZERO_BLANK_EN blanks leading zeros in number mode.
module reaction_display_mux
    import disp_pkg::*;
#(
    parameter int unsigned REFRESH_CYC = 100000,
    parameter int unsigned GAP_CYC     = 1000,
    parameter logic [3:0]  DP_MASK     = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic       ltr_flag,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    localparam int unsigned     CNT_W     = (REFRESH_CYC > 2) ? $clog2(REFRESH_CYC) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [1:0]        scan_idx_q, scan_idx_d;
    logic [3:0][3:0]   snap_q;
    logic              snap_ltr_q;
    logic              snap_valid_q;
    logic              frame_tick_q;
    disp_state_t       state_q;
    logic [3:0]        an_q;
    logic [7:0]        sseg_q;

    logic              slot_wrap;
    logic              frame_wrap;
    logic              lead_blank;
    logic [7:0]        dec_sseg;

    assign slot_wrap  = (slot_cnt_q == SLOT_LAST);
    assign frame_wrap = slot_wrap && (scan_idx_q == 2'd3);
    assign slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
    assign scan_idx_d = slot_wrap ? scan_idx_q + 2'd1 : scan_idx_q;

`ifdef LEAD_ZERO_BLANK_EN
    // Blank a digit when it and every more-significant digit are zero; digit0 always shows
    always_comb begin
        lead_blank = 1'b0;
        if (!snap_ltr_q) begin
            case (scan_idx_q)
                2'd3:    lead_blank = (snap_q[3] == 4'h0);
                2'd2:    lead_blank = (snap_q[3] == 4'h0) && (snap_q[2] == 4'h0);
                2'd1:    lead_blank = (snap_q[3] == 4'h0) && (snap_q[2] == 4'h0)
                                   && (snap_q[1] == 4'h0);
                default: lead_blank = 1'b0;
            endcase
        end
    end
`else
    assign lead_blank = 1'b0;
`endif

    seg_decoder u_seg_decoder (
        .code        (snap_q[scan_idx_q]),
        .ltr         (snap_ltr_q),
        .dp_en       (DP_MASK[scan_idx_q]),
        .blank_force (lead_blank),
        .sseg        (dec_sseg)
    );

    // Slot/scan counters and the once-per-frame input snapshot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt_q   <= '0;
            scan_idx_q   <= 2'd0;
            // NOTE: the snapshot bank is only 17 flops, so it is reset to blank
            // codes; that guarantees a dark display before the first frame.
            snap_q       <= {4{CODE_BLANK}};
            snap_ltr_q   <= 1'b0;
            snap_valid_q <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            slot_cnt_q   <= slot_cnt_d;
            scan_idx_q   <= scan_idx_d;
            frame_tick_q <= frame_wrap;
            if (frame_wrap) begin
                snap_q       <= {digit3, digit2, digit1, digit0};
                snap_ltr_q   <= ltr_flag;
                snap_valid_q <= 1'b1;
            end
        end
    end

    // Gap/show FSM with registered anode and segment outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= GAP;
            an_q    <= 4'b1111;
            sseg_q  <= SEG_BLANK;
        end else begin
            if ((state_q == SHOW) && snap_valid_q) begin
                an_q   <= ~(4'b0001 << scan_idx_q);
                sseg_q <= dec_sseg;
            end else begin
                an_q   <= 4'b1111;
                sseg_q <= SEG_BLANK;
            end

            case (state_q)
                GAP:     if ((GAP_CYC == 0) || (slot_cnt_q == GAP_LAST)) state_q <= SHOW;
                SHOW:    if ((GAP_CYC != 0) && slot_wrap) state_q <= GAP;
                default: state_q <= GAP;
            endcase
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/reaction_display_mux.md
Name: reaction_display_mux

Overview:
- Time-multiplexed 4-digit seven-segment driver.
- Consumes the reaction-timer control outputs (digit0..digit3, ltr_flag) and drives the board anodes and segments.
- Snapshots all inputs once per frame to prevent tearing.
- Inserts a blanking gap at each digit switch to suppress ghosting.

Parameters:
- REFRESH_CYC, 100000, clk cycles per digit slot (1 ms at 100 MHz); must be >= 2.
- GAP_CYC, 1000, blanked cycles at the start of each slot; must be < REFRESH_CYC; 0 disables the gap.
- DP_MASK, 4'b0000, per-digit decimal-point enable; bit i = digit i; number mode only.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- digit0  in  4  least-significant digit code
- digit1  in  4  digit code
- digit2  in  4  digit code
- digit3  in  4  most-significant digit code
- ltr_flag  in  1  1 = letter mode, 0 = number mode
- an  out  4  digit anodes, active-low; bit i = digit i
- sseg  out  8  segments, active-low; [6:0] = g..a, [7] = dp
- frame_tick  out  1  one-cycle pulse when a new input snapshot is taken

Behaviour:
- Reset (rst=0, async): an=4'b1111, sseg=8'hFF, frame_tick=0, slot counter=0, scan index=0, state=GAP, snapshot = all 4'hF with ltr_flag=0.
- Slot counter runs 0..REFRESH_CYC-1 and wraps. On wrap, the scan index increments mod 4 (0→1→2→3→0).
- Scan index 3→0 wrap: latch digit0..3 and ltr_flag into snapshot registers in the same cycle; frame_tick=1 for exactly that cycle.
- First snapshot occurs at the first 3→0 wrap after reset. Until then the display shows blank.
- FSM, two states:
  - GAP: an=4'b1111, sseg=8'hFF.
  - SHOW: an = one-hot-low at the scan index; sseg = decode of the snapshot digit at the scan index.
  - GAP→SHOW when slot counter == GAP_CYC-1.
  - SHOW→GAP on slot wrap.
  - GAP_CYC=0: FSM stays in SHOW permanently.
- Outputs are registered: an and sseg reflect the state/index of the previous cycle (1-cycle latency).
- Number mode decode:
  - 0..9 → standard glyphs ('0'=C0, '1'=F9, '5'=92, '8'=80, hex values).
  - 4'hF → blank (FF).
  - 4'hA..4'hE → blank.
  - dp bit = ~DP_MASK[i], then ANDed with blank: a blank digit never lights dp.
- Letter mode decode:
  - 4'h5 → 'H' (89).
  - 4'hA → 'I' (CF).
  - 4'hF → blank.
  - Any other code → blank.
  - dp always off.
- Input changes mid-frame have no effect until the next snapshot. Mixed-mode frames are impossible.
- Reset asserted mid-slot: all outputs blank immediately (async); counting restarts from 0 on deassertion.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined, number mode: contiguous leading 4'h0 codes starting at digit3 and moving downward are blanked; digit0 is never blanked. Example: 0,0,4,2 shows "  42".
- Defined, letter mode: no effect.
- Not defined: zeros are always displayed.

Decomposition:
- Package disp_pkg holds:
  - codes CODE_BLANK=4'hF, CODE_H=4'h5, CODE_I=4'hA
  - SEG_BLANK=8'hFF
  - glyph constants
  - disp_state_t enum {GAP, SHOW}
- One combinational sub-module, seg_decoder: inputs code, ltr, dp_en, blank_force; output sseg[7:0].
- All sequencing stays in reaction_display_mux.

Test Plan (REFRESH_CYC=8, GAP_CYC=2, DP_MASK=4'b0000 unless stated):
- Reset held, then released → an=1111, sseg=FF until the first frame_tick; first frame_tick 32 cycles after release.
- ltr_flag=1, digits {F,F,5,A} (digit3..digit0) → slot 0: an=1110, sseg=CF; slot 1: an=1101, sseg=89; slots 2–3: sseg=FF; each slot shows 2 cycles of an=1111 followed by 6 cycles lit.
- ltr_flag=0, digits {0,1,5,8}, DP_MASK=4'b1000 → slot 3 sseg=40 ('0' with dp); slot 0 sseg=80.
- Change digits to {9,9,9,9} mid-frame → no change on sseg until the cycle after the next frame_tick.
- GAP_CYC=0 → an never equals 1111 after the first snapshot; anode rotates every 8 cycles.
- With LEAD_ZERO_BLANK_EN: digits {0,0,0,0} → only digit0 lit ('0'=C0); {0,3,0,7} → digit3 blank, digits 2..0 show 3,0,7.
